// File: rtl/bus_pkg.sv
// Shared serial-bus definitions: field widths, R/W encoding and the slave FSM
// state encoding that the master port also decodes for cross-checking.
package bus_pkg;

    localparam int ADDR_W     = 12;
    localparam int DATA_W     = 8;
    localparam int SLAVE_ID_W = 2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_ADDR = 3'd1,
        S_RX_DATA = 3'd2,
        S_WR      = 3'd3,
        S_RD_REQ  = 3'd4,
        S_RD_WAIT = 3'd5,
        S_TX      = 3'd6,
        S_ACK     = 3'd7
    } slave_state_t;

endpackage

// File: rtl/serial_shift_reg.sv
// LSB-first shift register: serial-in capture, or parallel load then serial-out
// from bit 0.
module serial_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift,
    input  logic         shift_in,
    output logic [W-1:0] data
);

    // Bits enter at the MSB and drift toward bit 0, so after W shifts the first
    // received bit is at bit 0, which is also the next bit presented for TX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     data <= '0;
        else if (load)  data <= load_data;
        else if (shift) data <= {shift_in, data[W-1:1]};
    end

endmodule

// File: rtl/bus_slave_port.sv
// Slave end of the serial bus: deserialises a request frame, performs one
// memory access, then answers with an ack pulse or serial read data.
module bus_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_W      = bus_pkg::ADDR_W,
    parameter int DATA_W      = bus_pkg::DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              slave_sel,
    input  logic              s_valid,
    input  logic              s_in,
    output logic              s_out,
    output logic              s_out_valid,
    output logic              s_ack,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int RX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(RX_W);

    slave_state_t      state, state_n;
    logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [2:0]        wait_cnt, wait_cnt_n;
    logic              rw_q, rw_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [RX_W-1:0]   rx_data, rx_next;
    logic [DATA_W-1:0] tx_data;
    logic              take, rx_shift, tx_load, tx_shift;
    logic              unused_bits;

    assign take     = s_valid && slave_sel;
    assign rx_shift = take && (state == S_RX_ADDR || state == S_RX_DATA);
    assign tx_load  = (state == S_RD_WAIT) && (wait_cnt == 3'(MEM_LATENCY - 1));
    assign tx_shift = (state == S_TX);
    // Register contents as they will be after this cycle's bit is shifted in;
    // fields are captured from here on their final bit.
    assign rx_next  = {s_in, rx_data[RX_W-1:1]};

    serial_shift_reg #(.W(RX_W)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .load      (1'b0),
        .load_data ('0),
        .shift     (rx_shift),
        .shift_in  (s_in),
        .data      (rx_data)
    );

    serial_shift_reg #(.W(DATA_W)) u_tx (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_load),
        .load_data (mem_rdata),
        .shift     (tx_shift),
        .shift_in  (1'b0),
        .data      (tx_data)
    );

    assign unused_bits = ^{rx_data[0], tx_data[DATA_W-1:1]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            wait_cnt <= '0;
            rw_q     <= RW_WRITE;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            wait_cnt <= wait_cnt_n;
            rw_q     <= rw_n;
            addr_q   <= addr_n;
            wdata_q  <= wdata_n;
        end
    end

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        wait_cnt_n = wait_cnt;
        rw_n       = rw_q;
        addr_n     = addr_q;
        wdata_n    = wdata_q;
        case (state)
            S_IDLE: begin
                if (take) begin
                    rw_n      = s_in;
                    bit_cnt_n = '0;
                    state_n   = S_RX_ADDR;
                end
            end
            S_RX_ADDR: begin
                // Deselect wins over a bit arriving in the same cycle.
                if (!slave_sel) begin
                    state_n = S_IDLE;
                end else if (s_valid) begin
                    if (bit_cnt == CNT_W'(ADDR_W - 1)) begin
                        bit_cnt_n = '0;
                        addr_n    = rx_next[RX_W-1 -: ADDR_W];
                        state_n   = (rw_q == RW_READ) ? S_RD_REQ : S_RX_DATA;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_RX_DATA: begin
                if (!slave_sel) begin
                    state_n = S_IDLE;
                end else if (s_valid) begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_n = '0;
                        wdata_n   = rx_next[RX_W-1 -: DATA_W];
                        state_n   = S_WR;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end
            S_WR:     state_n = S_ACK;
            S_RD_REQ: begin
                wait_cnt_n = '0;
                state_n    = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (tx_load) begin
                    bit_cnt_n = '0;
                    state_n   = S_TX;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            S_TX: begin
                if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                    bit_cnt_n = '0;
                    state_n   = S_ACK;
                end else begin
                    bit_cnt_n = bit_cnt + 1'b1;
                end
            end
            S_ACK:    state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    assign busy        = (state != S_IDLE);
    assign mem_we      = (state == S_WR);
    assign mem_re      = (state == S_RD_REQ);
    assign s_ack       = (state == S_ACK);
    assign s_out_valid = (state == S_TX);
    assign s_out       = s_out_valid & tx_data[0];
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_slave_port.sv
// Bench for bus_slave_port: directed table of frames, a mid-TX async reset,
// then random frames scored against a frame-level memory model.
module tb_bus_slave_port;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int L  = 2;

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stall_at;
        int            stall_len;
        int            abort_at;
        int            exp_we;
        int            exp_re;
        int            exp_ack;
    } vec_t;

    typedef struct {
        logic v;
        logic sel;
        logic b;
    } slot_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          slave_sel = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_in = 1'b0;
    logic          s_out, s_out_valid, s_ack, busy, mem_we, mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad = 0;

    logic [DW-1:0] ref_mem [int];
    logic [AW-1:0] written [$];

    // Memory device: fixed read latency, junk on the bus outside the valid cycle.
    logic [DW-1:0] dev_mem [0:(1<<AW)-1];
    logic [L-1:0]  re_dly = '0;
    logic [AW-1:0] a_dly [L];
    logic [DW-1:0] junk = '0;

    bus_slave_port #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(L)) dut (
        .clk         (clk),
        .reset       (reset),
        .slave_sel   (slave_sel),
        .s_valid     (s_valid),
        .s_in        (s_in),
        .s_out       (s_out),
        .s_out_valid (s_out_valid),
        .s_ack       (s_ack),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) dev_mem[mem_addr] <= mem_wdata;
        re_dly[0] <= mem_re;
        a_dly[0]  <= mem_addr;
        for (int i = 1; i < L; i++) begin
            re_dly[i] <= re_dly[i-1];
            a_dly[i]  <= a_dly[i-1];
        end
    end

    always @(negedge clk) junk = DW'($urandom);

    assign mem_rdata = re_dly[L-1] ? dev_mem[a_dly[L-1]] : junk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rw, input int addr, input int data,
                                input int st_at, input int st_len, input int ab_at,
                                input int we, input int re, input int ack);
        vec_t v;
        v.rw = rw; v.addr = AW'(addr); v.data = DW'(data);
        v.stall_at = st_at; v.stall_len = st_len; v.abort_at = ab_at;
        v.exp_we = we; v.exp_re = re; v.exp_ack = ack;
        return v;
    endfunction

    // Drives one frame (cycle 0 = RW bit) and scores it; cut >= 0 stops early
    // after that cycle with no end-of-frame checks.
    task automatic run_frame(input vec_t v, input int cut);
        slot_t         sched [$];
        slot_t         s;
        logic          bits [$];
        logic [DW-1:0] exp_rd, tx_val, we_d;
        logic [AW-1:0] we_a, re_a;
        int abort_cyc, end_cyc, we_n, we_c, re_n, re_c, ack_n, ack_c, tx_n, tx_c, bad_out;
        bits.push_back(v.rw);
        for (int i = 0; i < AW; i++) bits.push_back(v.addr[i]);
        if (v.rw == 1'b0) for (int i = 0; i < DW; i++) bits.push_back(v.data[i]);
        abort_cyc = -1;
        for (int i = 0; i < bits.size(); i++) begin
            if (i == v.stall_at)
                for (int k = 0; k < v.stall_len; k++) begin
                    s.v = 1'b0; s.sel = 1'b1; s.b = 1'($urandom_range(0, 1));
                    sched.push_back(s);
                end
            if (i == v.abort_at) begin
                abort_cyc = sched.size();
                s.v = 1'b1; s.sel = 1'b0; s.b = bits[i];
                sched.push_back(s);
                break;
            end
            s.v = 1'b1; s.sel = 1'b1; s.b = bits[i];
            sched.push_back(s);
        end
        exp_rd = (v.rw && ref_mem.exists(int'(v.addr))) ? ref_mem[int'(v.addr)] : '0;
        end_cyc = (abort_cyc >= 0) ? abort_cyc + 2 : v.exp_ack;
        if (cut >= 0) end_cyc = cut;
        we_n = 0; we_c = -1; re_n = 0; re_c = -1; ack_n = 0; ack_c = -1;
        tx_n = 0; tx_c = -1; bad_out = 0;
        tx_val = '0; we_d = '0; we_a = '0; re_a = '0;
        for (int c = 0; c <= end_cyc; c++) begin
            @(posedge clk); #1;
            if (c < sched.size()) begin
                s_valid = sched[c].v; slave_sel = sched[c].sel; s_in = sched[c].b;
            end else begin
                s_valid = 1'b0; slave_sel = 1'b1; s_in = 1'b0;
            end
            @(negedge clk);
            if (c == 0) chk("idle_at_start", int'(busy), 0);
            if (c == 1) chk("busy_in_frame", int'(busy), 1);
            if (abort_cyc >= 0 && c == abort_cyc + 1) chk("abort_to_idle", int'(busy), 0);
            if (mem_we) begin we_n++; we_c = c; we_a = mem_addr; we_d = mem_wdata; end
            if (mem_re) begin re_n++; re_c = c; re_a = mem_addr; end
            if (s_ack)  begin ack_n++; ack_c = c; end
            if (s_out_valid) begin
                if (tx_n == 0) tx_c = c;
                if (tx_n < DW) tx_val[tx_n[2:0]] = s_out;
                tx_n++;
            end else if (s_out) begin
                bad_out++;
            end
        end
        if (cut >= 0) return;
        if (v.exp_we < 0) chk("we_count", we_n, 0);
        else begin
            chk("we_count", we_n, 1);
            chk("we_cycle", we_c, v.exp_we);
            chk("we_addr", int'(we_a), int'(v.addr));
            chk("we_data", int'(we_d), int'(v.data));
        end
        if (v.exp_re < 0) chk("re_count", re_n, 0);
        else begin
            chk("re_count", re_n, 1);
            chk("re_cycle", re_c, v.exp_re);
            chk("re_addr", int'(re_a), int'(v.addr));
        end
        if (v.exp_ack < 0) chk("ack_count", ack_n, 0);
        else begin
            chk("ack_count", ack_n, 1);
            chk("ack_cycle", ack_c, v.exp_ack);
        end
        if (v.rw && v.exp_ack >= 0) begin
            chk("tx_count", tx_n, DW);
            chk("tx_first_cycle", tx_c, v.exp_ack - DW);
            chk("tx_data", int'(tx_val), int'(exp_rd));
        end else begin
            chk("tx_count", tx_n, 0);
        end
        chk("s_out_zero_when_invalid", bad_out, 0);
        if (!v.rw && v.abort_at < 0) begin
            ref_mem[int'(v.addr)] = v.data;
            written.push_back(v.addr);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [14];
        vec_t v;
        int   nb, st;

        tbl[0]  = mk(1'b0, 1001, 101, -1, 0, -1, 21, -1, 22);
        tbl[1]  = mk(1'b1, 1001, 0,   -1, 0, -1, -1, 13, 24);
        tbl[2]  = mk(1'b0, 1001, 101,  7, 3, -1, 24, -1, 25);
        tbl[3]  = mk(1'b0, 1001, 'hEE, -1, 0, 17, -1, -1, -1);
        tbl[4]  = mk(1'b0, 9,    7,   -1, 0, -1, 21, -1, 22);
        tbl[5]  = mk(1'b1, 9,    0,   -1, 0, -1, -1, 13, 24);
        tbl[6]  = mk(1'b0, 1001, 102, -1, 0, -1, 21, -1, 22);
        tbl[7]  = mk(1'b1, 1001, 0,   -1, 0, -1, -1, 13, 24);
        tbl[8]  = mk(1'b0, 'hFFF, 'hFF, -1, 0, -1, 21, -1, 22);
        tbl[9]  = mk(1'b0, 0,    0,   -1, 0, -1, 21, -1, 22);
        tbl[10] = mk(1'b0, 5,    'h33, -1, 0, 20, -1, -1, -1);
        tbl[11] = mk(1'b1, 1001, 0,   -1, 0, 12, -1, -1, -1);
        tbl[12] = mk(1'b1, 'hFFF, 0,   3, 2, -1, -1, 15, 26);
        tbl[13] = mk(1'b1, 0,    0,   -1, 0, -1, -1, 13, 24);

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_re", int'(mem_re), 0);
        chk("rst_s_ack", int'(s_ack), 0);
        chk("rst_s_out_valid", int'(s_out_valid), 0);
        chk("rst_s_out", int'(s_out), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        @(negedge clk);
        reset = 1'b1;
        slave_sel = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 14; i++) run_frame(tbl[i], -1);

        // Async reset landing between edges while TX bit 4 is on the wire.
        run_frame(mk(1'b1, 1001, 0, -1, 0, -1, -1, 13, 22 + L), 14 + L + 4);
        chk("in_tx_before_reset", int'(s_out_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_s_out_valid", int'(s_out_valid), 0);
        chk("arst_s_out", int'(s_out), 0);
        chk("arst_s_ack", int'(s_ack), 0);
        chk("arst_mem_we", int'(mem_we), 0);
        chk("arst_mem_re", int'(mem_re), 0);
        chk("arst_mem_addr", int'(mem_addr), 0);
        chk("arst_mem_wdata", int'(mem_wdata), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_after_reset", int'(busy), 0);
        run_frame(tbl[7], -1);

        for (int n = 0; n < 40; n++) begin
            v.rw   = (written.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            v.addr = v.rw ? written[$urandom_range(0, written.size() - 1)]
                          : AW'($urandom_range(0, 15) * 273);
            v.data = DW'($urandom);
            nb = v.rw ? 1 + AW : 1 + AW + DW;
            v.stall_at = -1; v.stall_len = 0; v.abort_at = -1;
            if ($urandom_range(0, 5) == 0) begin
                v.abort_at = $urandom_range(1, nb - 1);
                v.exp_we = -1; v.exp_re = -1; v.exp_ack = -1;
            end else begin
                st = $urandom_range(0, 3);
                v.stall_at  = $urandom_range(1, nb - 1);
                v.stall_len = st;
                if (v.rw) begin
                    v.exp_we  = -1;
                    v.exp_re  = 1 + AW + st;
                    v.exp_ack = 1 + AW + 1 + L + DW + st;
                end else begin
                    v.exp_we  = 1 + AW + DW + st;
                    v.exp_re  = -1;
                    v.exp_ack = v.exp_we + 1;
                end
            end
            run_frame(v, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
